// File: rtl/icache_param.sv
// icache_param: parametrised set-associative read-only I-cache, true LRU.
// Ports: clk/rst, CPU fetch req/rsp, flush_req/flush_busy, memory burst read.
module icache_param #(
  parameter int NUM_SETS   = 8,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
);

  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int AGE_W = $clog2(NUM_WAYS);
  localparam int WAY_W = AGE_W;

  typedef enum logic [6:0] {
    S_WAIT   = 7'b0000001,
    S_LOOKUP = 7'b0000010,
    S_REQ    = 7'b0000100,
    S_RECV   = 7'b0001000,
    S_FILL   = 7'b0010000,
    S_FLUSH  = 7'b0100000,
    S_RESP   = 7'b1000000
  } state_t;

  state_t state_q, state_d;

  logic [31:2]      car_q;
  logic             flush_pend_q;
  logic [31:0]      rsp_data_q;
  logic [WAY_W-1:0] victim_q;
  logic [WRD_W-1:0] beat_q;
  logic [31:0]      buf_q [LINE_WORDS];

  logic             valid_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] age_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]      data_q  [NUM_SETS][NUM_WAYS][LINE_WORDS];

  logic [TAG_W-1:0] car_tag;
  logic [IDX_W-1:0] car_idx;
  logic [WRD_W-1:0] car_wrd;

  assign car_tag = car_q[31 -: TAG_W];
  assign car_idx = car_q[OFF_W +: IDX_W];
  assign car_wrd = car_q[2 +: WRD_W];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] vict_way;
  logic             upd_en;
  logic [WAY_W-1:0] upd_way;
  logic [AGE_W-1:0] upd_age;
  logic             accept;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    lru_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[car_idx][w] &&
          tag_q[car_idx][w] == car_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[car_idx][w] == AGE_W'(NUM_WAYS-1))
        lru_way = WAY_W'(w);
    end
    // Descending scan so the lowest invalid way wins.
    vict_way = lru_way;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!valid_q[car_idx][w])
        vict_way = WAY_W'(w);
    end
  end

  always_comb begin
    upd_en  = (state_q == S_LOOKUP && hit) ||
              (state_q == S_FILL);
    upd_way = (state_q == S_FILL) ? victim_q : hit_way;
    upd_age = age_q[car_idx][upd_way];
  end

  assign accept = (state_q == S_WAIT) && !flush_pend_q &&
                  from_cpu_inst_req_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (flush_pend_q)
          state_d = S_FLUSH;
        else if (from_cpu_inst_req_valid)
          state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = hit ? S_RESP : S_REQ;
      S_REQ: begin
        if (from_mem_rd_req_ready)
          state_d = S_RECV;
      end
      S_RECV: begin
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last)
          state_d = S_FILL;
      end
      S_FILL:  state_d = S_RESP;
      S_FLUSH: state_d = S_WAIT;
      S_RESP: begin
        if (from_cpu_cache_rsp_ready)
          state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      car_q        <= '0;
      flush_pend_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        car_q <= from_cpu_inst_req_addr[31:2];
      // A new request wins over the clear on entry to FLUSH.
      if (flush_req)
        flush_pend_q <= 1'b1;
      else if (state_q == S_WAIT)
        flush_pend_q <= 1'b0;
      if (state_q == S_REQ)
        beat_q <= '0;
      else if (state_q == S_RECV && from_mem_rd_rsp_valid)
        beat_q <= beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_q == S_FLUSH) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (state_q == S_FILL)
        valid_q[car_idx][victim_q] <= 1'b1;
      if (upd_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == upd_way)
            age_q[car_idx][w] <= '0;
          else if (age_q[car_idx][w] < upd_age)
            age_q[car_idx][w] <= age_q[car_idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_RECV && from_mem_rd_rsp_valid)
      buf_q[beat_q] <= from_mem_rd_rsp_data;
    if (state_q == S_LOOKUP) begin
      victim_q <= vict_way;
      if (hit)
        rsp_data_q <= data_q[car_idx][hit_way][car_wrd];
    end
    if (state_q == S_FILL) begin
      for (int i = 0; i < LINE_WORDS; i++)
        data_q[car_idx][victim_q][i] <= buf_q[i];
      tag_q[car_idx][victim_q] <= car_tag;
      rsp_data_q <= buf_q[car_wrd];
    end
  end

  assign to_cpu_inst_req_ready = !rst && state_q == S_WAIT &&
                                 !flush_pend_q;
  assign to_cpu_cache_rsp_valid = !rst && state_q == S_RESP;
  assign to_cpu_cache_rsp_data  = rst ? '0 : rsp_data_q;
  assign flush_busy = !rst && (flush_pend_q ||
                               state_q == S_FLUSH);
  assign to_mem_rd_req_valid = !rst && state_q == S_REQ;
  assign to_mem_rd_req_addr  = rst ? '0 :
    {car_tag, car_idx, {OFF_W{1'b0}}};
  assign to_mem_rd_rsp_ready = !rst && state_q == S_RECV;

endmodule
